// File: rtl/l2_req_arbiter_if.sv
// L2 request/response channel between the L1 request arbiter and the L2.
// master = arbiter side, slave = L2 side.
interface l2_req_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TIDW  = 2
);
  logic             l2_req_valid;
  logic             l2_req_ready;
  logic [WIDTH-1:0] l2_req_addr;
  logic [TIDW-1:0]  l2_req_tid;
  logic             l2_req_spec;
  logic             l2_valid_rsp;
  logic [TIDW-1:0]  l2_tid;

  modport master (
    output l2_req_valid, l2_req_addr, l2_req_tid, l2_req_spec,
    input  l2_req_ready, l2_valid_rsp, l2_tid
  );

  modport slave (
    input  l2_req_valid, l2_req_addr, l2_req_tid, l2_req_spec,
    output l2_req_ready, l2_valid_rsp, l2_tid
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 request port among the per-thread L1 I-caches.
// Class priority branch > refill > prefetch, round-robin within a class,
// one request outstanding, watchdog on the tagged response.
module l2_req_arbiter #(
  parameter int NTHR     = 4,
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NTHR-1:0]       br_req,
  input  logic [NTHR-1:0]       req_refill,
  input  logic [NTHR-1:0]       req_spec,
  input  logic [NTHR*WIDTH-1:0] req_addr,
  l2_req_arbiter_if.master      l2,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int TIDW = (NTHR > 1) ? $clog2(NTHR) : 1;
  localparam int CW   = $clog2(MAX_WAIT);
  localparam int LW   = WIDTH - 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                       state, state_n;
  logic   [TIDW-1:0]            rr_ptr;
  logic   [CW-1:0]              wait_cnt;
  logic   [TIDW-1:0]            tid_q;
  logic   [WIDTH-1:0]           addr_q;
  logic                         spec_q;
  logic                         valid_q;
  logic                         busy_q;
  logic                         tmo_q;

  logic [NTHR-1:0][WIDTH-1:0]   dem_addr;
  logic [NTHR-1:0][WIDTH-1:0]   spc_addr;
  logic [NTHR-1:0]              cls_vec;
  logic                         pick_spec;
  logic [TIDW-1:0]              pick_tid;
  logic [TIDW-1:0]              scan_idx;
  logic                         found;
  logic                         any_req;
  logic                         rsp_hit;
  logic                         expire;

  // Line addresses per thread; prefetch targets the next line, wrapping
  // within the line-index field so nothing carries out of the address.
  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    logic [LW-1:0] line;
    assign line        = req_addr[t*WIDTH+4 +: LW];
    assign dem_addr[t] = {line, 4'b0};
    assign spc_addr[t] = {LW'(line + 1'b1), 4'b0};
  end

  // Offset bits inside a line never reach the L2.
  logic unused_addr_lo;
  always_comb begin
    unused_addr_lo = 1'b0;
    for (int t = 0; t < NTHR; t++) unused_addr_lo ^= ^req_addr[t*WIDTH +: 4];
  end

  assign any_req = |(br_req | req_refill | req_spec);

  // Winner: highest non-empty class, then first set bit from rr_ptr upward.
  // A thread with branch and refill both set is just one branch request.
  always_comb begin
    pick_spec = 1'b0;
    cls_vec   = br_req;
    if (|br_req)          cls_vec = br_req;
    else if (|req_refill) cls_vec = req_refill;
    else begin
      cls_vec   = req_spec;
      pick_spec = 1'b1;
    end
    pick_tid = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NTHR; i++) begin
      scan_idx = rr_ptr + TIDW'(i);
      if (!found && cls_vec[scan_idx]) begin
        found    = 1'b1;
        pick_tid = scan_idx;
      end
    end
  end

  // Responses only count in WAIT, so one arriving with the handshake is dropped.
  assign rsp_hit = (state == WAIT) && l2.l2_valid_rsp && (l2.l2_tid == tid_q);
  assign expire  = (state == WAIT) && (wait_cnt == CW'(MAX_WAIT - 1));

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   if (l2.l2_req_ready) state_n = WAIT;
      WAIT:    if (rsp_hit || expire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus outputs registered alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= (state_n == ISSUE);
      busy_q  <= (state_n != IDLE);
    end
  end

  // Winner latch, wait counter, round-robin pointer and sticky timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tid_q    <= '0;
      addr_q   <= '0;
      spec_q   <= 1'b0;
      wait_cnt <= '0;
      rr_ptr   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        tid_q  <= pick_tid;
        addr_q <= pick_spec ? spc_addr[pick_tid] : dem_addr[pick_tid];
        spec_q <= pick_spec;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (rsp_hit || expire) rr_ptr <= tid_q + 1'b1;
      if (expire && !rsp_hit) tmo_q <= 1'b1;
    end
  end

  assign l2.l2_req_valid = valid_q;
  assign l2.l2_req_addr  = addr_q;
  assign l2.l2_req_tid   = tid_q;
  assign l2.l2_req_spec  = spec_q;
  assign busy            = busy_q;
  assign timeout_err     = tmo_q;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: reset, priority, round-robin,
// prefetch address wrap, ready stall and watchdog expiry.
module tb_l2_req_arbiter;
  localparam int NTHR     = 4;
  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 64;

  logic                  clock;
  logic                  reset;
  logic [NTHR-1:0]       br_req;
  logic [NTHR-1:0]       req_refill;
  logic [NTHR-1:0]       req_spec;
  logic [NTHR*WIDTH-1:0] req_addr;
  logic                  busy;
  logic                  timeout_err;

  int n_chk = 0;
  int n_err = 0;

  l2_req_arbiter_if #(.WIDTH(WIDTH), .TIDW(2)) l2if ();

  l2_req_arbiter #(.NTHR(NTHR), .WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .br_req      (br_req),
    .req_refill  (req_refill),
    .req_spec    (req_spec),
    .req_addr    (req_addr),
    .l2          (l2if.master),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_addr(input int t, input logic [31:0] a);
    req_addr[t*WIDTH +: WIDTH] = a;
  endtask

  // Request already applied in IDLE with ready=1: expect the grant next
  // cycle, then answer it immediately in the first WAIT cycle.
  task automatic grant(input string tag, input logic [1:0] t, input logic [31:0] a, input logic s);
    @(negedge clock);
    chk({tag, " valid"}, l2if.l2_req_valid, 1);
    chk({tag, " tid"},   l2if.l2_req_tid, t);
    chk({tag, " addr"},  l2if.l2_req_addr, a);
    chk({tag, " spec"},  l2if.l2_req_spec, s);
    @(negedge clock);
    chk({tag, " wait busy"},  busy, 1);
    chk({tag, " wait valid"}, l2if.l2_req_valid, 0);
    l2if.l2_valid_rsp = 1'b1;
    l2if.l2_tid       = t;
    @(negedge clock);
    l2if.l2_valid_rsp = 1'b0;
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    br_req = '0; req_refill = '0; req_spec = '0; req_addr = '0;
    l2if.l2_req_ready = 1'b0;
    l2if.l2_valid_rsp = 1'b0;
    l2if.l2_tid       = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst valid", l2if.l2_req_valid, 0);
    chk("rst addr",  l2if.l2_req_addr, 0);
    chk("rst tid",   l2if.l2_req_tid, 0);
    chk("rst spec",  l2if.l2_req_spec, 0);
    chk("rst busy",  busy, 0);
    chk("rst tmo",   timeout_err, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle no req", busy, 0);

    // T2: single refill, line-aligned address, latency 1.
    l2if.l2_req_ready = 1'b1;
    req_refill = 4'b0100;
    set_addr(2, 32'h0000_1238);
    grant("t2", 2'd2, 32'h0000_1230, 1'b0);
    req_refill = '0;

    // T3: class priority. rr_ptr is now 3.
    br_req[3] = 1'b1; req_refill[0] = 1'b1; req_spec[1] = 1'b1;
    set_addr(3, 32'h1234_567F);
    set_addr(0, 32'h0000_A00F);
    set_addr(1, 32'h0000_B017);
    grant("t3 br", 2'd3, 32'h1234_5670, 1'b0);
    br_req = '0;
    grant("t3 refill", 2'd0, 32'h0000_A000, 1'b0);
    req_refill = '0;
    grant("t3 spec", 2'd1, 32'h0000_B020, 1'b1);
    req_spec = '0;

    // T1: reset mid-ISSUE drops everything without waiting for a clock.
    l2if.l2_req_ready = 1'b0;
    req_refill = 4'b0010;
    @(negedge clock);
    chk("t1 pre valid", l2if.l2_req_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t1 valid", l2if.l2_req_valid, 0);
    chk("t1 addr",  l2if.l2_req_addr, 0);
    chk("t1 tid",   l2if.l2_req_tid, 0);
    chk("t1 spec",  l2if.l2_req_spec, 0);
    chk("t1 busy",  busy, 0);
    req_refill = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t1 idle", busy, 0);
    l2if.l2_valid_rsp = 1'b1;
    l2if.l2_tid       = 2'd1;
    @(negedge clock);
    l2if.l2_valid_rsp = 1'b0;
    chk("t1 stale rsp", busy, 0);
    chk("t1 stale valid", l2if.l2_req_valid, 0);

    // T4: round-robin over all refill requesters, rr_ptr restarts at 0.
    l2if.l2_req_ready = 1'b1;
    for (int t = 0; t < NTHR; t++) set_addr(t, 32'(t * 32'h100 + 5));
    req_refill = 4'b1111;
    grant("t4 g0", 2'd0, 32'h0000_0000, 1'b0);
    grant("t4 g1", 2'd1, 32'h0000_0100, 1'b0);
    grant("t4 g2", 2'd2, 32'h0000_0200, 1'b0);
    grant("t4 g3", 2'd3, 32'h0000_0300, 1'b0);
    grant("t4 g4", 2'd0, 32'h0000_0000, 1'b0);
    req_refill = '0;

    // T5: prefetch next-line wraps to zero.
    req_spec[1] = 1'b1;
    set_addr(1, 32'hFFFF_FFFC);
    grant("t5", 2'd1, 32'h0000_0000, 1'b1);
    req_spec = '0;

    // T6: ready stall, then watchdog with only foreign-TID responses.
    l2if.l2_req_ready = 1'b0;
    req_refill[3] = 1'b1;
    set_addr(3, 32'h0000_4444);
    @(negedge clock);
    chk("t6 valid", l2if.l2_req_valid, 1);
    chk("t6 tid",   l2if.l2_req_tid, 3);
    chk("t6 addr",  l2if.l2_req_addr, 32'h0000_4440);
    chk("t6 spec",  l2if.l2_req_spec, 0);
    req_refill = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t6 stall valid", l2if.l2_req_valid, 1);
      chk("t6 stall addr",  l2if.l2_req_addr, 32'h0000_4440);
      chk("t6 stall tid",   l2if.l2_req_tid, 3);
    end
    // Matching response in the handshake cycle must be ignored.
    l2if.l2_req_ready = 1'b1;
    l2if.l2_valid_rsp = 1'b1;
    l2if.l2_tid       = 2'd3;
    @(negedge clock);
    l2if.l2_tid = 2'd0;
    chk("t6 hs rsp ignored", busy, 1);
    chk("t6 wait valid", l2if.l2_req_valid, 0);
    repeat (MAX_WAIT - 1) @(negedge clock);
    chk("t6 last wait busy", busy, 1);
    chk("t6 last wait tmo",  timeout_err, 0);
    @(negedge clock);
    chk("t6 expired busy", busy, 0);
    chk("t6 expired tmo",  timeout_err, 1);
    l2if.l2_valid_rsp = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6 tmo sticky", timeout_err, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
